// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave valid-ready bus arbiter with round-robin grants,
// transaction locking until ready, and a per-transfer timeout watchdog.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned TIMEOUT_W = 16,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        timeout_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_C = TIMEOUT_W'(TIMEOUT);
  localparam logic                 WD_EN     = (TIMEOUT != 0);

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  // Owner-side request selected by the current lock.
  logic                 own_sel_s;
  logic                 own_valid_s;
  logic [31:0]          own_addr_s;
  logic [31:0]          own_wdata_s;
  logic [3:0]           own_wstrb_s;
  logic                 timeout_s;
  logic                 own_ready_s;
  logic [31:0]          own_rdata_s;

  // State, round-robin pointer, watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request mux for the locked master.
  always_comb begin
    own_sel_s   = (state_q == BUSY1);
    own_valid_s = own_sel_s ? m1_valid : m0_valid;
    own_addr_s  = own_sel_s ? m1_addr  : m0_addr;
    own_wdata_s = own_sel_s ? m1_wdata : m0_wdata;
    own_wstrb_s = own_sel_s ? m1_wstrb : m0_wstrb;
  end

  // Arbitration, lock release, watchdog and bus steering.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    timeout_s   = 1'b0;
    own_ready_s = 1'b0;
    own_rdata_s = 32'h0000_0000;
    s_valid     = 1'b0;
    s_addr      = 32'h0000_0000;
    s_wdata     = 32'h0000_0000;
    s_wstrb     = 4'b0000;
    grant       = 2'b00;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_valid && m1_valid) begin
          state_d = last_q ? BUSY0 : BUSY1;
        end else if (m0_valid) begin
          state_d = BUSY0;
        end else if (m1_valid) begin
          state_d = BUSY1;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY0, BUSY1: begin
        grant   = own_sel_s ? 2'b10 : 2'b01;
        s_addr  = own_addr_s;
        s_wdata = own_wdata_s;
        s_wstrb = own_wstrb_s;
        cnt_d   = cnt_q + TIMEOUT_W'(1);
        // A master that has already withdrawn is aborted, never timed out.
        timeout_s = WD_EN && own_valid_s && (cnt_q == TIMEOUT_C) && !s_ready;
        if (timeout_s) begin
          s_valid     = 1'b0;
          own_ready_s = 1'b1;
          own_rdata_s = ERR_RDATA;
          state_d     = IDLE;
          last_d      = own_sel_s;
        end else begin
          s_valid     = own_valid_s;
          own_ready_s = s_ready;
          own_rdata_s = s_rdata;
          if (!own_valid_s) begin
            state_d = IDLE;
          end else if (s_ready) begin
            state_d = IDLE;
            last_d  = own_sel_s;
          end else begin
            state_d = state_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Completion steering: only the lock owner ever sees ready or rdata.
  always_comb begin
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = 32'h0000_0000;
    m1_rdata = 32'h0000_0000;
    if (state_q == BUSY0) begin
      m0_ready = own_ready_s;
      m0_rdata = own_rdata_s;
    end else if (state_q == BUSY1) begin
      m1_ready = own_ready_s;
      m1_rdata = own_rdata_s;
    end else begin
      m0_ready = 1'b0;
      m1_ready = 1'b0;
    end
  end

  assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Cycle-vector bench for mem_bus_arbiter (TIMEOUT=8) with an expectation queue.
module tb_mem_bus_arbiter;

  localparam logic [31:0] A0   = 32'h0000_0010;
  localparam logic [31:0] W0   = 32'h0000_0000;
  localparam logic [3:0]  S0   = 4'b0000;
  localparam logic [31:0] A1   = 32'h0000_0020;
  localparam logic [31:0] W1   = 32'hAABB_CCDD;
  localparam logic [3:0]  S1   = 4'b0011;
  localparam logic [31:0] SRD  = 32'h1234_5678;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

  logic        clk, rstn;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        s_valid, s_ready, timeout_err, err_clr;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       m0v, m1v, sr, clr;
    logic [1:0] gnt;
    logic       sv, m0r, m1r, to, err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  mem_bus_arbiter #(.TIMEOUT(8), .TIMEOUT_W(16), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .rstn(rstn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic m0v, m1v, sr, clr, input logic [1:0] gnt,
                              input logic sv, m0r, m1r, to, err);
    vec_t v;
    v.m0v = m0v; v.m1v = m1v; v.sr = sr; v.clr = clr; v.gnt = gnt;
    v.sv = sv; v.m0r = m0r; v.m1r = m1r; v.to = to; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input vec_t e);
    logic [31:0] ea, ew, e0, e1;
    logic [3:0]  es;
    ea = (e.gnt == 2'b01) ? A0 : (e.gnt == 2'b10) ? A1 : 32'h0;
    ew = (e.gnt == 2'b01) ? W0 : (e.gnt == 2'b10) ? W1 : 32'h0;
    es = (e.gnt == 2'b01) ? S0 : (e.gnt == 2'b10) ? S1 : 4'b0000;
    e0 = e.gnt[0] ? (e.to ? ERRW : SRD) : 32'h0;
    e1 = e.gnt[1] ? (e.to ? ERRW : SRD) : 32'h0;
    chk({tag, " grant"},       {30'd0, grant},       {30'd0, e.gnt});
    chk({tag, " s_valid"},     {31'd0, s_valid},     {31'd0, e.sv});
    chk({tag, " m0_ready"},    {31'd0, m0_ready},    {31'd0, e.m0r});
    chk({tag, " m1_ready"},    {31'd0, m1_ready},    {31'd0, e.m1r});
    chk({tag, " timeout_err"}, {31'd0, timeout_err}, {31'd0, e.err});
    chk({tag, " s_addr"},      s_addr,               ea);
    chk({tag, " s_wdata"},     s_wdata,              ew);
    chk({tag, " s_wstrb"},     {28'd0, s_wstrb},     {28'd0, es});
    chk({tag, " m0_rdata"},    m0_rdata,             e0);
    chk({tag, " m1_rdata"},    m1_rdata,             e1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    m0_valid = v.m0v; m1_valid = v.m1v; s_ready = v.sr; err_clr = v.clr;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk_outputs(tag, e);
  endtask

  task automatic chk_all_zero(input string tag);
    vec_t z;
    z = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_outputs(tag, z);
  endtask

  initial begin
    rstn = 1'b0; err_clr = 1'b0; s_rdata = SRD;
    m0_addr = A0; m0_wdata = W0; m0_wstrb = S0;
    m1_addr = A1; m1_wdata = W1; m1_wstrb = S1;
    m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1;
    #2;
    chk_all_zero("reset");
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Both masters held, slave always ready: m0 first, then strict alternation.
    tbl.push_back(mk(1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2'b01, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2'b10, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2'b01, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    // Single m0 read, slave answers in its second granted cycle.
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 2'b01, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    // m1 write locked while m0 arrives mid-transfer.
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2'b10, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    // m0 granted, slave silent: cnt 0..7 waiting, cnt 8 forces error completion.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2'b01, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
    // Second timeout with err_clr in the same cycle: the set wins.
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 2'b01, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    // m1 aborts after 3 busy cycles; last stays m0 so the next tie goes to m1.
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2'b10, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset in the middle of BUSY0 with s_ready pending.
    run_vec("rst_a", mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    run_vec("rst_b", mk(1, 0, 1, 0, 2'b01, 1, 1, 0, 0, 0));
    run_vec("rst_c", mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    run_vec("rst_d", mk(1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0));
    #1;
    s_ready = 1'b1;
    #1;
    chk("rst_pre m0_ready", {31'd0, m0_ready}, 32'd1);
    rstn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    m0_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_vec("post_a", mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    run_vec("post_b", mk(1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0));
    run_vec("post_c", mk(1, 1, 1, 0, 2'b01, 1, 1, 0, 0, 0));
    run_vec("post_d", mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
